// File: rtl/gs_decimalizer_seq.sv
// rtl/gs_decimalizer_seq.sv - time-shared multi-channel binary-to-BCD converter (double dabble)
// Optional macro GS_DECIMALIZER_BLANK_EN generates the leading-zero blank_mask logic.
module gs_decimalizer_seq #(
  parameter int CHANNELS = 6,
  parameter int W_IN     = 8,
  parameter int DIGITS   = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [CHANNELS*W_IN-1:0]        in_values,
  output logic                            busy,
  output logic                            done,
  output logic [CHANNELS*DIGITS*4-1:0]    bcd_out,
  output logic [CHANNELS-1:0]             overflow,
  output logic [CHANNELS*DIGITS-1:0]      blank_mask
);

  localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CW  = (W_IN > 1) ? $clog2(W_IN) : 1;
  localparam int BW  = DIGITS * 4;
  localparam logic [CHW-1:0] LAST_CH  = CHW'(CHANNELS - 1);
  localparam logic [CW-1:0]  LAST_BIT = CW'(W_IN - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, STORE} state_t;

  state_t                   r_state, w_next_state;
  logic [CHW-1:0]           r_ch;
  logic [CW-1:0]            r_cnt;
  logic [CHANNELS*W_IN-1:0] r_snap;
  logic [W_IN-1:0]          r_bin, w_sel_value, w_bin_shift;
  logic [BW-1:0]            r_acc, w_adj, w_acc_shift, w_res_bcd;
  logic                     r_sticky, w_carry, w_last, r_done;
  logic [CHANNELS*BW-1:0]   r_stage_bcd, w_merge_bcd, r_bcd;
  logic [CHANNELS-1:0]      r_stage_ovf, w_merge_ovf, r_ovf;

  assign w_last   = (r_ch == LAST_CH);
  assign done     = r_done;
  assign bcd_out  = r_bcd;
  assign overflow = r_ovf;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state decode; busy is simply "not idle", so it drops in the done cycle
  always_comb begin
    w_next_state = r_state;
    busy         = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_next_state = LOAD;
      end
      LOAD:    w_next_state = SHIFT;
      SHIFT:   if (r_cnt == LAST_BIT) w_next_state = STORE;
      STORE:   w_next_state = w_last ? IDLE : LOAD;
      default: w_next_state = IDLE;
    endcase
  end

  // Pick the snapshot value of the channel being converted
  always_comb begin
    w_sel_value = '0;
    for (int c = 0; c < CHANNELS; c++)
      if (CHW'(c) == r_ch) w_sel_value = r_snap[c*W_IN +: W_IN];
  end

  // Add-3 correction then one-bit shift; the bit leaving the top digit is a 10^DIGITS carry
  always_comb begin
    w_adj = r_acc;
    for (int d = 0; d < DIGITS; d++)
      if (r_acc[d*4 +: 4] >= 4'd5) w_adj[d*4 +: 4] = r_acc[d*4 +: 4] + 4'd3;
    {w_carry, w_acc_shift, w_bin_shift} = {w_adj, r_bin, 1'b0};
  end

  // Saturate to all nines on overflow and merge the channel result into the staged set
  always_comb begin
    w_res_bcd   = r_sticky ? {DIGITS{4'h9}} : r_acc;
    w_merge_bcd = r_stage_bcd;
    w_merge_ovf = r_stage_ovf;
    for (int c = 0; c < CHANNELS; c++) begin
      if (CHW'(c) == r_ch) begin
        w_merge_bcd[c*BW +: BW] = w_res_bcd;
        w_merge_ovf[c]          = r_sticky;
      end
    end
  end

`ifdef GS_DECIMALIZER_BLANK_EN
  logic [DIGITS-1:0]          w_res_blank;
  logic [CHANNELS*DIGITS-1:0] r_stage_blank, w_merge_blank, r_blank;

  assign blank_mask = r_blank;

  // Blank a digit when it and every more significant digit are zero; digit 0 always shows
  always_comb begin
    logic v_zero_run;
    v_zero_run    = 1'b1;
    w_res_blank   = '0;
    for (int d = DIGITS - 1; d > 0; d--) begin
      v_zero_run     = v_zero_run & (r_acc[d*4 +: 4] == 4'd0);
      w_res_blank[d] = v_zero_run & ~r_sticky;
    end
    w_merge_blank = r_stage_blank;
    for (int c = 0; c < CHANNELS; c++)
      if (CHW'(c) == r_ch) w_merge_blank[c*DIGITS +: DIGITS] = w_res_blank;
  end
`else
  assign blank_mask = '0;
`endif

  // Datapath: snapshot, per-channel conversion, staging and atomic publish of results
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ch          <= '0;
      r_cnt         <= '0;
      r_snap        <= '0;
      r_bin         <= '0;
      r_acc         <= '0;
      r_sticky      <= 1'b0;
      r_done        <= 1'b0;
      r_stage_bcd   <= '0;
      r_stage_ovf   <= '0;
      r_bcd         <= '0;
      r_ovf         <= '0;
`ifdef GS_DECIMALIZER_BLANK_EN
      r_stage_blank <= '0;
      r_blank       <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_snap <= in_values;
            r_ch   <= '0;
          end
        end
        LOAD: begin
          r_bin    <= w_sel_value;
          r_acc    <= '0;
          r_sticky <= 1'b0;
          r_cnt    <= '0;
        end
        SHIFT: begin
          r_acc <= w_acc_shift;
          r_bin <= w_bin_shift;
          r_cnt <= r_cnt + CW'(1);
          if (w_carry) r_sticky <= 1'b1;
        end
        STORE: begin
          r_stage_bcd <= w_merge_bcd;
          r_stage_ovf <= w_merge_ovf;
`ifdef GS_DECIMALIZER_BLANK_EN
          r_stage_blank <= w_merge_blank;
`endif
          if (w_last) begin
            r_bcd  <= w_merge_bcd;
            r_ovf  <= w_merge_ovf;
`ifdef GS_DECIMALIZER_BLANK_EN
            r_blank <= w_merge_blank;
`endif
            r_done <= 1'b1;
          end else begin
            r_ch <= r_ch + CHW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gs_decimalizer_seq.sv
// tb/tb_gs_decimalizer_seq.sv - self-checking bench for gs_decimalizer_seq
module tb_gs_decimalizer_seq;

  localparam int CH = 6, WI = 8, DG = 2;
  localparam int CH2 = 2, WI2 = 10, DG2 = 3;
  localparam int LAT1 = CH * (WI + 2);
  localparam int LAT2 = CH2 * (WI2 + 2);

  logic        clk = 1'b0;
  logic        reset, start, start2;
  logic [47:0] in_values;
  logic        busy, done;
  logic [47:0] bcd_out;
  logic [5:0]  overflow;
  logic [11:0] blank_mask;
  logic [19:0] in_values2;
  logic        busy2, done2;
  logic [23:0] bcd_out2;
  logic [1:0]  overflow2;
  logic [5:0]  blank_mask2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gs_decimalizer_seq #(.CHANNELS(CH), .W_IN(WI), .DIGITS(DG)) u_dut (
    .clk(clk), .reset(reset), .start(start), .in_values(in_values),
    .busy(busy), .done(done), .bcd_out(bcd_out), .overflow(overflow),
    .blank_mask(blank_mask)
  );

  gs_decimalizer_seq #(.CHANNELS(CH2), .W_IN(WI2), .DIGITS(DG2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .in_values(in_values2),
    .busy(busy2), .done(done2), .bcd_out(bcd_out2), .overflow(overflow2),
    .blank_mask(blank_mask2)
  );

  typedef struct {
    logic [47:0] vals;
    logic [47:0] bcd;
    logic [5:0]  ovf;
    logic [11:0] blank;
  } vec_t;

  vec_t tbl[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Decimal reference for one value: plain division, saturation and leading-zero test
  function automatic void ref_channel(input int v, input int digits,
                                      output logic [19:0] bcd, output logic ovf,
                                      output logic [4:0] blank);
    int lim;
    int p;
    lim = 1;
    for (int d = 0; d < digits; d++) lim = lim * 10;
    ovf   = (v >= lim);
    bcd   = '0;
    blank = '0;
    p     = 1;
    for (int d = 0; d < digits; d++) begin
      bcd[d*4 +: 4] = ovf ? 4'h9 : 4'((v / p) % 10);
      blank[d]      = (d > 0) && !ovf && (v < p);
      p = p * 10;
    end
  endfunction

  function automatic void model1(input logic [47:0] vals, output logic [47:0] eb,
                                 output logic [5:0] eo, output logic [11:0] ebl);
    logic [19:0] b;
    logic        o;
    logic [4:0]  bl;
    for (int c = 0; c < CH; c++) begin
      ref_channel(int'(vals[c*WI +: WI]), DG, b, o, bl);
      eb[c*8 +: 8]  = b[7:0];
      eo[c]         = o;
      ebl[c*2 +: 2] = bl[1:0];
    end
`ifndef GS_DECIMALIZER_BLANK_EN
    ebl = '0;
`endif
  endfunction

  function automatic void model2(input logic [19:0] vals, output logic [23:0] eb,
                                 output logic [1:0] eo, output logic [5:0] ebl);
    logic [19:0] b;
    logic        o;
    logic [4:0]  bl;
    for (int c = 0; c < CH2; c++) begin
      ref_channel(int'(vals[c*WI2 +: WI2]), DG2, b, o, bl);
      eb[c*12 +: 12] = b[11:0];
      eo[c]          = o;
      ebl[c*3 +: 3]  = bl[2:0];
    end
`ifndef GS_DECIMALIZER_BLANK_EN
    ebl = '0;
`endif
  endfunction

  task automatic check_outputs1(input string tag, input logic [47:0] vals);
    logic [47:0] eb;
    logic [5:0]  eo;
    logic [11:0] ebl;
    model1(vals, eb, eo, ebl);
    check({tag, "_bcd"}, bcd_out, eb);
    check({tag, "_ovf"}, overflow, eo);
    check({tag, "_blank"}, blank_mask, ebl);
  endtask

  // Counts cycles (and busy cycles) until done is seen, bounded
  task automatic wait_done(input string tag, output int cycles, output int busy_cycles);
    cycles = 0;
    busy_cycles = 0;
    while (!done && cycles < 400) begin
      if (busy) busy_cycles++;
      step();
      cycles++;
    end
    check({tag, "_done_seen"}, done, 1'b1);
  endtask

  task automatic run_and_check(input string tag, input logic [47:0] vals);
    int cyc, bc;
    in_values = vals;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(tag, cyc, bc);
    check({tag, "_latency"}, cyc, LAT1);
    check({tag, "_busy_cycles"}, bc, LAT1);
    check({tag, "_busy_in_done"}, busy, 1'b0);
    check_outputs1(tag, vals);
    step();
    check({tag, "_done_one_cycle"}, done, 1'b0);
  endtask

  task automatic run2(input string tag, input logic [19:0] vals);
    int cyc;
    logic [23:0] eb;
    logic [1:0]  eo;
    logic [5:0]  ebl;
    in_values2 = vals;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    cyc = 0;
    while (!done2 && cyc < 400) begin
      step();
      cyc++;
    end
    check({tag, "_done_seen"}, done2, 1'b1);
    check({tag, "_latency"}, cyc, LAT2);
    model2(vals, eb, eo, ebl);
    check({tag, "_bcd"}, bcd_out2, eb);
    check({tag, "_ovf"}, overflow2, eo);
    check({tag, "_blank"}, blank_mask2, ebl);
  endtask

  function automatic logic [7:0] pick_value();
    logic [7:0] edges[6];
    edges = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd255};
    if ($urandom_range(0, 2) == 0) return edges[$urandom_range(0, 5)];
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    int cyc, bc, ndone;
    logic [47:0] v;
    logic [47:0] t1;
    logic [11:0] tb_blank;
    logic [19:0] v2;

    tbl[0] = '{48'hFF_07_00_63_14_15, 48'h99_07_00_99_20_21, 6'b100000, 12'b00_10_10_00_00_00};
    tbl[1] = '{48'h64_0A_09_01_62_32, 48'h99_10_09_01_98_50, 6'b100000, 12'b00_00_10_10_00_00};
    tbl[2] = '{48'h00_00_00_00_00_00, 48'h00_00_00_00_00_00, 6'b000000, 12'b10_10_10_10_10_10};
    tbl[3] = '{48'hC7_65_C8_96_80_7F, 48'h99_99_99_99_99_99, 6'b111111, 12'b00_00_00_00_00_00};
    t1 = tbl[0].vals;

    reset = 1'b1;
    start = 1'b0;
    start2 = 1'b0;
    in_values = '0;
    in_values2 = '0;
    repeat (3) step();
    reset = 1'b0;
    step();
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_bcd", bcd_out, 48'h0);
    check("reset_ovf", overflow, 6'h0);
    check("reset_blank", blank_mask, 12'h0);

    // Table vectors against fixed expected values
    for (int i = 0; i < 4; i++) begin
      run_and_check($sformatf("tbl%0d", i), tbl[i].vals);
      tb_blank = tbl[i].blank;
`ifndef GS_DECIMALIZER_BLANK_EN
      tb_blank = '0;
`endif
      check($sformatf("tbl%0d_const_bcd", i), bcd_out, tbl[i].bcd);
      check($sformatf("tbl%0d_const_ovf", i), overflow, tbl[i].ovf);
      check($sformatf("tbl%0d_const_blank", i), blank_mask, tb_blank);
    end

    // start held high: back-to-back conversions, start in done cycle accepted
    in_values = t1;
    start = 1'b1;
    step();
    wait_done("held1", cyc, bc);
    check("held1_latency", cyc, LAT1);
    check_outputs1("held1", t1);
    step();
    check("held_restart_busy", busy, 1'b1);
    check("held_restart_nodone", done, 1'b0);
    wait_done("held2", cyc, bc);
    start = 1'b0;
    check("held2_latency", cyc, LAT1);
    check("held2_busy_cycles", bc, LAT1);
    check_outputs1("held2", t1);
    step();
    check("held_stop_busy", busy, 1'b0);

    // Input change and extra start mid-conversion are ignored
    in_values = t1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    in_values[7:0] = 8'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("snap", cyc, bc);
    check("snap_latency", cyc + 10, LAT1);
    check_outputs1("snap", t1);
    check("snap_ch0", bcd_out[7:0], 8'h21);
    step();
    check("snap_no_requeue", busy, 1'b0);
    v = t1;
    v[7:0] = 8'd5;
    run_and_check("snap_second", v);
    check("snap_second_ch0", bcd_out[7:0], 8'h05);

    // Reset mid-conversion aborts with no done pulse
    in_values = tbl[1].vals;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (29) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_bcd", bcd_out, 48'h0);
    check("abort_ovf", overflow, 6'h0);
    check("abort_blank", blank_mask, 12'h0);
    ndone = 0;
    for (int i = 0; i < 100; i++) begin
      if (done) ndone++;
      step();
    end
    check("abort_no_done", ndone, 0);
    run_and_check("after_abort", t1);

    // Randomized values against the reference model
    for (int i = 0; i < 16; i++) begin
      for (int c = 0; c < CH; c++) v[c*8 +: 8] = pick_value();
      run_and_check($sformatf("rand%0d", i), v);
    end

    // Wider-input, three-digit instance
    run2("w10_edge", {10'd1000, 10'd999});
    check("w10_edge_const_bcd", bcd_out2, 24'h999_999);
    check("w10_edge_const_ovf", overflow2, 2'b10);
    for (int i = 0; i < 6; i++) begin
      v2 = {10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023))};
      run2($sformatf("w10_rand%0d", i), v2);
    end
    run2("w10_small", {10'd7, 10'd0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
